// File: rtl/ex_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: instruction controls and operands in,
// EX/MEM payload, stall and redirect out.
interface ex_if;
    localparam int unsigned W    = 16;
    localparam int unsigned WB_W = 23;

    logic [WB_W-1:0] wb;
    logic            m;
    logic [3:0]      aluop;
    logic            alusrc1;
    logic [1:0]      alusrc2;
    logic            id_update;
    logic            jr;
    logic            pcload;
    logic            exec;
    logic [W-1:0]    pc_plus_1;
    logic [W-1:0]    dataa;
    logic [W-1:0]    datab;
    logic [11:0]     jumpaddr;
    logic [3:0]      imm_value;
    logic [7:0]      branchaddr;

    logic            ex_stall;
    logic            redirect;
    logic [W-1:0]    target;
    logic [WB_W-1:0] wb_out;
    logic            m_out;
    logic [W-1:0]    result;
    logic [W-1:0]    store_data;
    logic [3:0]      flags;

    modport master (
        output wb, m, aluop, alusrc1, alusrc2, id_update, jr, pcload, exec,
               pc_plus_1, dataa, datab, jumpaddr, imm_value, branchaddr,
        input  ex_stall, redirect, target, wb_out, m_out, result, store_data, flags
    );

    modport slave (
        input  wb, m, aluop, alusrc1, alusrc2, id_update, jr, pcload, exec,
               pc_plus_1, dataa, datab, jumpaddr, imm_value, branchaddr,
        output ex_stall, redirect, target, wb_out, m_out, result, store_data, flags
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU, 16-iteration shift-add multiplier,
// jump/branch resolution and the {Z,N,C,V} flags register feeding EX/MEM.
module ex_stage (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    localparam int unsigned W     = 16;
    localparam int unsigned WB_W  = 23;
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0]       OP_ADD  = 4'd0;
    localparam logic [3:0]       OP_SUB  = 4'd1;
    localparam logic [3:0]       OP_AND  = 4'd2;
    localparam logic [3:0]       OP_OR   = 4'd3;
    localparam logic [3:0]       OP_XOR  = 4'd4;
    localparam logic [3:0]       OP_NOT  = 4'd5;
    localparam logic [3:0]       OP_SLL  = 4'd6;
    localparam logic [3:0]       OP_SRL  = 4'd7;
    localparam logic [3:0]       OP_SRA  = 4'd8;
    localparam logic [3:0]       OP_MUL  = 4'd9;
    localparam logic [3:0]       OP_PASS = 4'd10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);

    typedef enum logic [0:0] {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [WB_W-1:0]  wb_hold_q, wb_hold_d;
    logic             m_hold_q, m_hold_d;
    logic             upd_hold_q, upd_hold_d;
    logic [W-1:0]     st_hold_q, st_hold_d;
    logic [WB_W-1:0]  wb_out_q, wb_out_d;
    logic             m_out_q, m_out_d;
    logic [W-1:0]     result_q, result_d;
    logic [W-1:0]     store_q, store_d;
    logic [3:0]       flags_q, flags_d;

    logic [W-1:0]     op_a, op_b;
    logic [W:0]       sum17;
    logic [W-1:0]     alu_res;
    logic             alu_c, alu_v;
    logic             mul_go, stall_c;
    logic             redirect_c;
    logic [W-1:0]     target_c;
    logic [W-1:0]     acc_next;

    // Operand select and single-cycle ALU
    always_comb begin
        op_a    = bus.alusrc1 ? bus.pc_plus_1 : bus.dataa;
        op_b    = bus.datab;
        sum17   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alusrc2)
            2'd0:    op_b = bus.datab;
            2'd1:    op_b = {12'd0, bus.imm_value};
            2'd2:    op_b = {{8{bus.branchaddr[7]}}, bus.branchaddr};
            default: op_b = W'(1);
        endcase
        case (bus.aluop)
            OP_ADD: begin
                sum17   = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum17[W-1:0];
                alu_c   = sum17[W];
                alu_v   = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
            end
            OP_SUB: begin
                sum17   = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
                alu_res = sum17[W-1:0];
                alu_c   = sum17[W];
                alu_v   = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_SLL:  alu_res = op_a << op_b[3:0];
            OP_SRL:  alu_res = op_a >> op_b[3:0];
            OP_SRA:  alu_res = W'($signed(op_a) >>> op_b[3:0]);
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Stall and control transfer; a multiply in flight never redirects
    always_comb begin
        mul_go     = (state_q == IDLE) && (bus.aluop == OP_MUL);
        stall_c    = mul_go || (state_q == BUSY);
        redirect_c = 1'b0;
        target_c   = '0;
        if (!stall_c) begin
            if (bus.jr) begin
                redirect_c = 1'b1;
                target_c   = bus.dataa;
            end else if (bus.pcload) begin
                redirect_c = 1'b1;
                target_c   = {bus.pc_plus_1[15:12], bus.jumpaddr};
            end else if (bus.exec && flags_q[3]) begin
                redirect_c = 1'b1;
                target_c   = bus.pc_plus_1 + {{8{bus.branchaddr[7]}}, bus.branchaddr};
            end
        end
    end

    // Next-state: multiplier FSM and EX/MEM register; EX/MEM defaults to a bubble
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        wb_hold_d  = wb_hold_q;
        m_hold_d   = m_hold_q;
        upd_hold_d = upd_hold_q;
        st_hold_d  = st_hold_q;
        wb_out_d   = '0;
        m_out_d    = 1'b0;
        result_d   = '0;
        store_d    = '0;
        flags_d    = flags_q;
        acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        case (state_q)
            IDLE: begin
                if (mul_go) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    mcand_d    = op_a;
                    mplier_d   = op_b;
                    acc_d      = '0;
                    wb_hold_d  = bus.wb;
                    m_hold_d   = bus.m;
                    upd_hold_d = bus.id_update;
                    st_hold_d  = bus.datab;
                end else begin
                    wb_out_d = bus.wb;
                    m_out_d  = bus.m;
                    result_d = alu_res;
                    store_d  = bus.datab;
                    if (bus.id_update) begin
                        flags_d = {alu_res == '0, alu_res[W-1], alu_c, alu_v};
                    end
                end
            end
            BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    wb_out_d = wb_hold_q;
                    m_out_d  = m_hold_q;
                    result_d = acc_next;
                    store_d  = st_hold_q;
                    if (upd_hold_q) begin
                        flags_d = {acc_next == '0, acc_next[W-1], 1'b0, 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            wb_hold_q  <= '0;
            m_hold_q   <= 1'b0;
            upd_hold_q <= 1'b0;
            st_hold_q  <= '0;
            wb_out_q   <= '0;
            m_out_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            wb_hold_q  <= wb_hold_d;
            m_hold_q   <= m_hold_d;
            upd_hold_q <= upd_hold_d;
            st_hold_q  <= st_hold_d;
            wb_out_q   <= wb_out_d;
            m_out_q    <= m_out_d;
            result_q   <= result_d;
            store_q    <= store_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.ex_stall   = stall_c;
    assign bus.redirect   = redirect_c;
    assign bus.target     = target_c;
    assign bus.wb_out     = wb_out_q;
    assign bus.m_out      = m_out_q;
    assign bus.result     = result_q;
    assign bus.store_data = store_q;
    assign bus.flags      = flags_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, flags, branches/jumps, multiplier timing and reset abort.
module tb_ex_stage;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ex_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop();
        bus.wb         = '0;
        bus.m          = 1'b0;
        bus.aluop      = 4'd0;
        bus.alusrc1    = 1'b0;
        bus.alusrc2    = 2'd0;
        bus.id_update  = 1'b0;
        bus.jr         = 1'b0;
        bus.pcload     = 1'b0;
        bus.exec       = 1'b0;
        bus.pc_plus_1  = '0;
        bus.dataa      = '0;
        bus.datab      = '0;
        bus.jumpaddr   = '0;
        bus.imm_value  = '0;
        bus.branchaddr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if ({bus.wb_out, bus.m_out, bus.result, bus.store_data, bus.flags, bus.ex_stall} !== '0) begin
            fails++;
            $display("FAIL reset: wb_out=%h m_out=%b result=%h store=%h flags=%b stall=%b required all zero",
                     bus.wb_out, bus.m_out, bus.result, bus.store_data, bus.flags, bus.ex_stall);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        set_nop();
        bus.aluop = 4'd0; bus.dataa = 16'h7FFF; bus.alusrc2 = 2'd3;
        bus.id_update = 1'b1; bus.wb = 23'h1ABCD; bus.m = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.redirect !== 1'b0 || bus.target !== 16'h0000) begin
            fails++;
            $display("FAIL add_no_redirect: redirect=%b target=%h required 0/0000", bus.redirect, bus.target);
        end
        tick();
        // branch on Z is not taken: flags now Z=0
        set_nop();
        bus.exec = 1'b1; bus.branchaddr = 8'h05; bus.pc_plus_1 = 16'h0020;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h8000 || bus.flags !== 4'b0101) begin
            fails++;
            $display("FAIL add_ovf: result=%h flags=%b required 8000/0101", bus.result, bus.flags);
        end
        tests++;
        if (bus.wb_out !== 23'h1ABCD || bus.m_out !== 1'b1) begin
            fails++;
            $display("FAIL add_ctrl: wb_out=%h m_out=%b required 1abcd/1", bus.wb_out, bus.m_out);
        end
        tests++;
        if (bus.redirect !== 1'b0 || bus.target !== 16'h0000) begin
            fails++;
            $display("FAIL branch_not_taken: redirect=%b target=%h required 0/0000", bus.redirect, bus.target);
        end
        tick();
        set_nop();
    endtask

    task automatic test_sub_branch();
        set_nop();
        bus.aluop = 4'd1; bus.dataa = 16'd5; bus.datab = 16'd5; bus.id_update = 1'b1;
        tick();
        set_nop();
        bus.exec = 1'b1; bus.branchaddr = 8'hFE; bus.pc_plus_1 = 16'h0010;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h0000 || bus.flags !== 4'b1010) begin
            fails++;
            $display("FAIL sub_zero: result=%h flags=%b required 0000/1010", bus.result, bus.flags);
        end
        tests++;
        if (bus.redirect !== 1'b1 || bus.target !== 16'h000E) begin
            fails++;
            $display("FAIL branch_taken: redirect=%b target=%h required 1/000e", bus.redirect, bus.target);
        end
        tick();
        set_nop();
    endtask

    task automatic test_mul();
        set_nop();
        bus.aluop = 4'd9; bus.dataa = 16'h0123; bus.datab = 16'h0010;
        bus.id_update = 1'b1; bus.wb = 23'h00055; bus.m = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ex_stall !== 1'b1 || bus.redirect !== 1'b0) begin
            fails++;
            $display("FAIL mul_present: stall=%b redirect=%b required 1/0", bus.ex_stall, bus.redirect);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            @(negedge clk);
            tests++;
            if (bus.ex_stall !== 1'b1 || bus.wb_out !== '0 || bus.m_out !== 1'b0 || bus.result !== '0) begin
                fails++;
                $display("FAIL mul_busy cycle %0d: stall=%b wb_out=%h m_out=%b result=%h required 1/0/0/0",
                         i, bus.ex_stall, bus.wb_out, bus.m_out, bus.result);
            end
        end
        tick();
        set_nop();
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h1230 || bus.wb_out !== 23'h00055 || bus.ex_stall !== 1'b0) begin
            fails++;
            $display("FAIL mul_done: result=%h wb_out=%h stall=%b required 1230/00055/0",
                     bus.result, bus.wb_out, bus.ex_stall);
        end
        tests++;
        if (bus.flags !== 4'b0000) begin
            fails++;
            $display("FAIL mul_flags: flags=%b required 0000", bus.flags);
        end
        tick();
    endtask

    task automatic test_jump();
        set_nop();
        bus.jr = 1'b1; bus.pcload = 1'b1; bus.dataa = 16'hBEEF;
        bus.pc_plus_1 = 16'h3456; bus.jumpaddr = 12'hABC;
        @(negedge clk);
        tests++;
        if (bus.redirect !== 1'b1 || bus.target !== 16'hBEEF) begin
            fails++;
            $display("FAIL jr_priority: redirect=%b target=%h required 1/beef", bus.redirect, bus.target);
        end
        tick();
        bus.jr = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.redirect !== 1'b1 || bus.target !== 16'h3ABC) begin
            fails++;
            $display("FAIL pcload: redirect=%b target=%h required 1/3abc", bus.redirect, bus.target);
        end
        tick();
        set_nop();
    endtask

    task automatic test_rst_mid_mul();
        set_nop();
        bus.aluop = 4'd9; bus.dataa = 16'h1234; bus.datab = 16'h0003; bus.id_update = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        set_nop();
        bus.aluop = 4'd0; bus.dataa = 16'hFFFF; bus.datab = 16'h0003;
        bus.alusrc2 = 2'd0; bus.id_update = 1'b1; bus.wb = 23'h00011;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.ex_stall !== 1'b0 || bus.result !== '0 || bus.wb_out !== '0 || bus.flags !== 4'b0000) begin
            fails++;
            $display("FAIL rst_abort: stall=%b result=%h wb_out=%h flags=%b required 0/0000/0/0000",
                     bus.ex_stall, bus.result, bus.wb_out, bus.flags);
        end
        tick();
        set_nop();
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h0002 || bus.flags !== 4'b0010 || bus.store_data !== 16'h0003
            || bus.wb_out !== 23'h00011) begin
            fails++;
            $display("FAIL add_after_rst: result=%h flags=%b store=%h wb_out=%h required 0002/0010/0003/00011",
                     bus.result, bus.flags, bus.store_data, bus.wb_out);
        end
        tick();
    endtask

    task automatic test_shifts_misc();
        set_nop();
        bus.aluop = 4'd8; bus.dataa = 16'h8000; bus.alusrc2 = 2'd1; bus.imm_value = 4'd4;
        bus.id_update = 1'b1;
        tick();
        set_nop();
        bus.aluop = 4'd6; bus.dataa = 16'h0001; bus.alusrc2 = 2'd1; bus.imm_value = 4'hF;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'hF800 || bus.flags !== 4'b0100) begin
            fails++;
            $display("FAIL sra: result=%h flags=%b required f800/0100", bus.result, bus.flags);
        end
        tick();
        set_nop();
        bus.aluop = 4'd12; bus.dataa = 16'h0005; bus.datab = 16'h0007;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h8000 || bus.flags !== 4'b0100) begin
            fails++;
            $display("FAIL sll_noupd: result=%h flags=%b required 8000/0100", bus.result, bus.flags);
        end
        tick();
        set_nop();
        bus.aluop = 4'd10; bus.alusrc2 = 2'd2; bus.branchaddr = 8'h80; bus.wb = 23'h7FFFFF;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h0000 || bus.store_data !== 16'h0007) begin
            fails++;
            $display("FAIL reserved_op: result=%h store=%h required 0000/0007", bus.result, bus.store_data);
        end
        tick();
        set_nop();
        @(negedge clk);
        tests++;
        if (bus.result !== 16'hFF80 || bus.wb_out !== 23'h7FFFFF) begin
            fails++;
            $display("FAIL pass_sext: result=%h wb_out=%h required ff80/7fffff", bus.result, bus.wb_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        set_nop();
        bus.aluop = 4'd9; bus.dataa = 16'd3; bus.datab = 16'd5; bus.wb = 23'h00001;
        for (int i = 0; i < 17; i++) tick();
        bus.dataa = 16'hFFFF; bus.datab = 16'hFFFF; bus.wb = 23'h00007; bus.id_update = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h000F || bus.wb_out !== 23'h00001 || bus.ex_stall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: result=%h wb_out=%h stall=%b required 000f/00001/1",
                     bus.result, bus.wb_out, bus.ex_stall);
        end
        for (int i = 0; i < 17; i++) tick();
        set_nop();
        @(negedge clk);
        tests++;
        if (bus.result !== 16'h0001 || bus.wb_out !== 23'h00007 || bus.ex_stall !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: result=%h wb_out=%h stall=%b required 0001/00007/0",
                     bus.result, bus.wb_out, bus.ex_stall);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        set_nop();
        test_reset();
        test_add_overflow();
        test_sub_branch();
        test_mul();
        test_jump();
        test_rst_mid_mul();
        test_shifts_misc();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline, directly downstream of the ID/EX pipeline register. It selects operands, runs the ALU (single-cycle ops plus a 16-cycle shift-add multiplier), resolves jumps and branches, and maintains the Z/N/C/V flags register. Results are registered into the EX/MEM boundary. A stall is raised to freeze upstream stages while a multiply is in flight.

## Interface
- No parameters; datapath width fixed at 16.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb  in  23  writeback control from ID/EX
- m  in  1  memory-write control from ID/EX
- aluop  in  4  operation select
- alusrc1  in  1  operand A select: 0 dataa, 1 pc_plus_1
- alusrc2  in  2  operand B select: 0 datab, 1 zero-ext imm_value, 2 sign-ext branchaddr, 3 constant 1
- id_update  in  1  update flags with this instruction's result
- jr, pcload, exec  in  1 each  register-jump, absolute-jump, conditional-branch (on Z)
- pc_plus_1, dataa, datab  in  16 each
- jumpaddr  in  12;  imm_value  in  4;  branchaddr  in  8
- ex_stall  out  1  freeze IF, IF/ID and ID/EX (hold contents; not a bubble insert)
- redirect  out  1  combinational: taken control transfer this cycle
- target  out  16  combinational redirect PC
- wb_out  out  23;  m_out  out  1;  result  out  16;  store_data  out  16  (EX/MEM register)
- flags  out  4  {Z,N,C,V} register

## Operation
- aluop: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL A by B[3:0], 7 SRL, 8 SRA, 9 MUL (low 16 bits of A*B, unsigned), 10 PASS B, 11-15 result 0.
- ADD/SUB: 17-bit sum of A + B (SUB: A + ~B + 1); C = bit 16, V = signed overflow. Logic, shift, PASS, MUL, reserved: C = V = 0.
- Flags written only when id_update=1, on the cycle result is registered: Z = (result==0), N = result[15].
- Control transfer priority jr > pcload > exec. jr: target = dataa. pcload: target = {pc_plus_1[15:12], jumpaddr}. exec: taken iff flags.Z (current register value, before this instruction's update); target = pc_plus_1 + sext(branchaddr). redirect=0 and target=0 when none taken.
- store_data = datab. Non-MUL ops register wb_out/m_out/result on the next edge.
- MUL state machine, states IDLE, BUSY:
  - IDLE with aluop=9: load multiplicand A, multiplier B, accumulator 0, counter 0; go BUSY; ex_stall=1.
  - BUSY: per cycle, if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After the 16th iteration, register result = acc, wb_out/m_out from held inputs, flags if id_update; return to IDLE; ex_stall=0 that cycle.
  - While in IDLE-to-BUSY and BUSY, EX/MEM outputs a bubble (wb_out=0, m_out=0, result=0); redirect=0.
- Bubble from ID/EX (all-zero controls, aluop 0) passes as ADD of zeros with wb_out=0; flags untouched since id_update=0.

## Timing
- Reset: wb_out=0, m_out=0, result=0, store_data=0, flags=0, ex_stall=0, state IDLE, counter 0. rst mid-multiply aborts; ex_stall=0 from the next cycle.
- Single-cycle ops: latency 1 edge to EX/MEM.
- MUL: ex_stall combinationally high in the cycle aluop=9 is presented in IDLE and stays high for 16 following cycles; result registered on the 17th edge after presentation; ex_stall low during the cycle after that edge.
- redirect/target are combinational in the cycle the instruction sits in EX; the fetch/flush logic samples them at the next edge.
- Back-to-back MUL: the second MUL is presented after the first completes and restarts from IDLE with no gap cycle.

## Test plan
- Reset then ADD A=0x7FFF, B=1 (alusrc2=3), id_update=1 -> next edge result=0x8000, flags Z=0 N=1 C=0 V=1.
- SUB 5-5 with id_update=1, then exec=1 branchaddr=0xFE, pc_plus_1=0x0010 -> result=0, Z=1; redirect=1, target=0x000E.
- MUL 0x0123 * 0x0010 -> ex_stall high 17 cycles, bubbles on EX/MEM, then result=0x1230, ex_stall drops.
- jr=1 and pcload=1 together, dataa=0xBEEF -> redirect=1, target=0xBEEF.
- rst asserted at cycle 8 of a MUL -> all outputs 0, ex_stall 0 next cycle; new ADD executes normally.
- SRA A=0x8000 B=imm 4 -> result=0xF800, C=V=0.
